dmem_access_sequencer: RTL and testbench
========================================

Name: dmem_access_sequencer

Overview:
- Multi-cycle sequencer between the core's load/store control and a word-wide data-memory bus with a valid/ready handshake.
- Converts each byte, halfword or word access into one aligned bus transaction, or into two transactions when the access crosses a word boundary.
- Generates the core stall and returns aligned, sign- or zero-extended load data.

Parameters:
ADDR_WIDTH, 32, byte address width for req_addr and bus_addr

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  core has a load/store; held high while stall=1
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed  in  1  sign-extend load result (lb/lh)
req_wdata  in  32  store data, right-aligned
stall  out  1  freeze PC and register writeback
done  out  1  one-cycle pulse, access complete
rsp_rdata  out  32  load result, valid while done=1
bus_valid  out  1  transaction request
bus_ready  in  1  transaction accepted/completed this cycle
bus_write  out  1  store beat
bus_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=00
bus_mask  out  4  byte enables
bus_wdata  out  32  lane-aligned store data
bus_rdata  in  32  read data, valid in the cycle bus_ready=1 for a read

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bus_valid=0, done=0, rsp_rdata=0.
  - All latched request fields and the read buffer clear to 0.
  - stall is forced 0 while rst=0.
- States: IDLE, FIRST, SECOND, DONE.
- IDLE: when req_valid=1, latch write, addr, size, signed and wdata.
  - off = addr[1:0]; nb = 1/2/4 from size.
  - split = (off + nb > 4).
  - Go to FIRST.
- FIRST:
  - bus_valid=1, bus_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - bus_mask = low 4 bits of (bytemask(nb) << off).
  - bus_wdata = wdata << 8*off.
  - On bus_ready=1, capture bus_rdata into buf_lo. Go to SECOND if split, else DONE.
- SECOND:
  - bus_valid=1, bus_addr = aligned addr + 4, modulo 2^ADDR_WIDTH (wraps at the top of memory).
  - bus_mask = (bytemask(nb) << off) >> 4.
  - bus_wdata = wdata >> 8*(4-off).
  - On bus_ready=1, capture buf_hi. Go to DONE.
- DONE:
  - done=1, bus_valid=0.
  - Loads: rsp_rdata = low nb bytes of ({buf_hi, buf_lo} >> 8*off), sign-extended if signed=1, else zero-extended.
  - Stores: rsp_rdata=0.
  - Always go to IDLE next cycle, regardless of req_valid, because the request is consumed.
- stall = (state==IDLE & req_valid) | state==FIRST | state==SECOND; stall=0 in DONE.
- The core commits writeback in the DONE cycle.
- Latency:
  - Aligned access with zero wait states: 3 cycles from accept to done, stall high 2 cycles.
  - Split access: 4 cycles, stall high 3 cycles.
  - Each bus wait cycle adds 1 cycle.
- Handshake rules:
  - While bus_valid=1 and bus_ready=0, bus_addr, bus_mask, bus_wdata and bus_write hold stable.
  - bus_valid is never withdrawn before bus_ready.
  - bus_ready is ignored when bus_valid=0.
- bus_write = latched write in FIRST and SECOND; 0 otherwise.
- A back-to-back request (req_valid still high in the cycle after DONE) is accepted as a new access from IDLE.
- Reset mid-access: bus_valid drops immediately, the partial transaction is abandoned and no done pulse is produced.
- A new access may begin once rst=1.

Test Plan:
- Aligned lbu:
  - Stimulus: addr 0x3001, bus_rdata 0x1234F678, ready with no wait.
  - Required: one beat to 0x3000 with mask 0010; rsp_rdata 0x000000F6; stall high 2 cycles; done pulses once.
- Split sw:
  - Stimulus: addr 0x1002, wdata 0xAABBCCDD.
  - Required: beat 1 to 0x1000 with mask 1100, wdata 0xCCDD0000; beat 2 to 0x1004 with mask 0011, wdata 0x0000AABB; done in cycle 4.
- Split signed lh:
  - Stimulus: addr 0x2003, beat 1 rdata 0x80000000, beat 2 rdata 0x000000FF.
  - Required: masks 1000 then 0001; rsp_rdata 0xFFFFFF80.
- Backpressure:
  - Stimulus: aligned lw at 0x4000 with bus_ready low for 3 cycles.
  - Required: bus_addr, bus_mask and bus_valid stable throughout; stall high 5 cycles; rsp_rdata equals bus_rdata.
- Wrap:
  - Stimulus: lw at 0xFFFFFFFE.
  - Required: beats to 0xFFFFFFFC (mask 1100) and 0x00000000 (mask 0011).
- Reset mid-SECOND:
  - Stimulus: split store; assert rst=0 in the second beat.
  - Required: bus_valid=0 and stall=0 immediately, no done pulse; a subsequent aligned sb at 0x10 completes normally with mask 0001.

Source files
------------

// File: rtl/dmem_access_sequencer.sv
// dmem_access_sequencer: splits core byte/half/word accesses into aligned valid/ready bus beats
module dmem_access_sequencer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic                  bus_write_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_mask_o,
    output logic [31:0]           bus_wdata_o,
    input  logic [31:0]           bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_e;
    state_e                state_q, state_d;
    logic                  write_q, write_d, signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d, off;
    logic [31:0]           wdata_q, wdata_d, buf_lo_q, buf_lo_d, buf_hi_q, buf_hi_d, rdata_w;
    logic [3:0]            bytes;
    logic [7:0]            mask_w;
    logic [63:0]           wdata_w;
    logic                  split;
    // Byte-lane geometry of the latched access across the two candidate words
    always_comb begin
        off     = addr_q[1:0];
        bytes   = size_q == 2'b00 ? 4'b0001 : size_q == 2'b01 ? 4'b0011 : 4'b1111;
        mask_w  = {4'b0000, bytes} << off;
        split   = |mask_w[7:4];
        wdata_w = {32'h0, wdata_q} << {off, 3'b000};
        rdata_w = 32'({buf_hi_q, buf_lo_q} >> {off, 3'b000});
    end
    // Next-state and request/read-buffer update logic
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        buf_lo_d = buf_lo_q;
        buf_hi_d = buf_hi_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                write_d  = req_write_i;
                addr_d   = req_addr_i;
                size_d   = req_size_i;
                signed_d = req_signed_i;
                wdata_d  = req_wdata_i;
                state_d  = FIRST;
            end
            FIRST: if (bus_ready_i) begin
                buf_lo_d = bus_rdata_i;
                state_d  = split ? SECOND : DONE;
            end
            SECOND: if (bus_ready_i) begin
                buf_hi_d = bus_rdata_i;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and latched request registers; reset abandons any access in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'h0;
            buf_lo_q <= 32'h0;
            buf_hi_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            buf_lo_q <= buf_lo_d;
            buf_hi_q <= buf_hi_d;
        end
    end
    // Bus beat, stall and load-result outputs decoded from the current state
    always_comb begin
        bus_valid_o = state_q == FIRST || state_q == SECOND;
        bus_write_o = bus_valid_o & write_q;
        bus_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00} + (state_q == SECOND ? ADDR_WIDTH'(4) : '0);
        bus_mask_o  = state_q == FIRST ? mask_w[3:0] : state_q == SECOND ? mask_w[7:4] : 4'b0000;
        bus_wdata_o = state_q == FIRST ? wdata_w[31:0] : state_q == SECOND ? wdata_w[63:32] : 32'h0;
        stall_o     = rst_ni & ((state_q == IDLE & req_valid_i) | bus_valid_o);
        done_o      = state_q == DONE;
        rsp_rdata_o = (!done_o || write_q) ? 32'h0 :
                      size_q == 2'b00 ? {{24{signed_q & rdata_w[7]}}, rdata_w[7:0]} :
                      size_q == 2'b01 ? {{16{signed_q & rdata_w[15]}}, rdata_w[15:0]} : rdata_w;
    end
endmodule

// File: tb/tb_dmem_access_sequencer.sv
// tb_dmem_access_sequencer: scoreboard bench with byte-level memory reference model
module tb_dmem_access_sequencer;
    logic        clk = 1'b0;
    logic        rst_ni, req_valid, req_write, req_signed, stall, done;
    logic        bus_valid, bus_ready, bus_write;
    logic [31:0] req_addr, req_wdata, rsp_rdata, bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  req_size;
    logic [3:0]  bus_mask;

    always #5 clk = ~clk;

    dmem_access_sequencer #(.ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_signed_i(req_signed),
        .req_wdata_i(req_wdata), .stall_o(stall), .done_o(done), .rsp_rdata_o(rsp_rdata),
        .bus_valid_o(bus_valid), .bus_ready_i(bus_ready), .bus_write_o(bus_write),
        .bus_addr_o(bus_addr), .bus_mask_o(bus_mask), .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata)
    );

    typedef struct {logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; logic write;} beat_t;
    typedef struct {logic [31:0] rdata; int beats;} rsp_t;
    beat_t       beat_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] seen_addr[$], seen_wdata[$], last_rsp;
    logic [3:0]  seen_mask[$];
    logic [31:0] mem_w[logic [31:0]];
    logic [7:0]  mb[logic [31:0]];
    int          checks = 0, errors = 0, done_cnt = 0, last_stall = 0;
    int          fixed_waits = -1, wcnt = 0;
    bit          in_beat = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_w(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] rd_w(input logic [31:0] a);
        return mem_w.exists(a) ? mem_w[a] : init_w(a);
    endfunction

    function automatic logic [7:0] model_b(input logic [31:0] a);
        logic [31:0] t;
        if (mb.exists(a)) return mb[a];
        t = init_w({a[31:2], 2'b00}) >> {a[1:0], 3'b000};
        return t[7:0];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem_w[a] = v;
        for (int i = 0; i < 4; i++) mb[a + 32'(i)] = v[8*i +: 8];
    endtask

    // Reference: place each request byte into its lane, then into beat 1 or beat 2
    task automatic model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        int          nb, off, lane;
        beat_t       b1, b2;
        rsp_t        r;
        logic [31:0] v;
        nb  = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        off = int'(a[1:0]);
        b1  = '{addr: {a[31:2], 2'b00}, mask: 4'h0, wdata: 32'h0, write: w};
        b2  = '{addr: {a[31:2], 2'b00} + 32'd4, mask: 4'h0, wdata: 32'h0, write: w};
        for (int i = 0; i < 4; i++) begin
            lane = off + i;
            if (lane < 4) begin
                b1.wdata[8*lane +: 8] = wd[8*i +: 8];
                if (i < nb) b1.mask[lane] = 1'b1;
            end else begin
                b2.wdata[8*(lane-4) +: 8] = wd[8*i +: 8];
                if (i < nb) b2.mask[lane-4] = 1'b1;
            end
        end
        beat_q.push_back(b1);
        if (b2.mask != 4'h0) beat_q.push_back(b2);
        r.beats = b2.mask != 4'h0 ? 2 : 1;
        v = 32'h0;
        if (w) begin
            for (int i = 0; i < nb; i++) mb[a + 32'(i)] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = model_b(a + 32'(i));
            for (int i = nb; i < 4; i++) v[8*i +: 8] = (sg && v[8*nb-1]) ? 8'hFF : 8'h00;
        end
        r.rdata = v;
        rsp_q.push_back(r);
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd);
        int n = 0;
        model(w, a, sz, sg, wd);
        req_write = w; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
        req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) check("req_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        seen_addr.delete(); seen_mask.delete(); seen_wdata.delete();
    endtask

    // Bus slave: random wait states, word memory, random ready while idle
    initial begin
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_valid) begin
                if (!in_beat) begin
                    in_beat = 1;
                    wcnt = fixed_waits >= 0 ? fixed_waits : ($urandom % 3 == 0 ? int'($urandom_range(1, 3)) : 0);
                end
                if (wcnt > 0) begin
                    bus_ready = 1'b0;
                    bus_rdata = $urandom;
                    wcnt--;
                end else begin
                    bus_ready = 1'b1;
                    bus_rdata = rd_w(bus_addr);
                    in_beat = 0;
                end
            end else begin
                bus_ready = 1'($urandom % 2);
                bus_rdata = $urandom;
            end
            @(negedge clk);
            if (rst_ni && bus_valid && bus_ready && bus_write) begin
                logic [31:0] t;
                t = rd_w(bus_addr);
                for (int i = 0; i < 4; i++) if (bus_mask[i]) t[8*i +: 8] = bus_wdata[8*i +: 8];
                mem_w[bus_addr] = t;
            end
        end
    end

    // Monitor: pops expected beats/responses whenever the DUT presents them
    initial begin
        int          stall_cnt = 0, waits = 0, beats = 0;
        bit          prev_wait = 0;
        logic [69:0] prev_vec = '0;
        beat_t       b;
        rsp_t        r;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                stall_cnt = 0; waits = 0; beats = 0; prev_wait = 0;
                continue;
            end
            if (prev_wait) check("hold_stable", {bus_valid, bus_write, bus_addr, bus_mask, bus_wdata}, prev_vec);
            prev_wait = bus_valid && !bus_ready;
            prev_vec  = {bus_valid, bus_write, bus_addr, bus_mask, bus_wdata};
            if (stall) stall_cnt++;
            if (bus_valid && !bus_ready) waits++;
            if (bus_valid && bus_ready) begin
                beats++;
                seen_addr.push_back(bus_addr);
                seen_mask.push_back(bus_mask);
                seen_wdata.push_back(bus_wdata);
                if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    b = beat_q.pop_front();
                    check("beat_addr", bus_addr, b.addr);
                    check("beat_mask", bus_mask, b.mask);
                    check("beat_wdata", bus_wdata, b.wdata);
                    check("beat_write", bus_write, b.write);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_idle", {bus_valid, stall}, 0);
                if (rsp_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("beat_count", beats, r.beats);
                    check("stall_cycles", stall_cnt, 1 + r.beats + waits);
                end
                last_rsp = rsp_rdata; last_stall = stall_cnt;
                stall_cnt = 0; waits = 0; beats = 0;
            end
        end
    end

    initial begin
        int n, dc;
        rst_ni = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3001;
        req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus_valid, bus_write, done, stall, rsp_rdata}, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1; req_valid = 1'b0;
        idle(1);

        preload(32'h3000, 32'h1234F678);
        clear_seen();
        do_req(0, 32'h3001, 2'b00, 0, 32'h0);
        check("lbu_rsp", last_rsp, 32'h000000F6);
        check("lbu_stall", last_stall, 2);
        check("lbu_beat", {32'(seen_addr.size()), seen_addr[0], seen_mask[0]}, {32'd1, 32'h3000, 4'b0010});
        idle(2);

        clear_seen();
        do_req(1, 32'h1002, 2'b10, 0, 32'hAABBCCDD);
        check("sw_split_n", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            check("sw_beat1", {seen_addr[0], seen_mask[0], seen_wdata[0]}, {32'h1000, 4'b1100, 32'hCCDD0000});
            check("sw_beat2", {seen_addr[1], seen_mask[1], seen_wdata[1]}, {32'h1004, 4'b0011, 32'h0000AABB});
        end
        idle(1);

        preload(32'h2000, 32'h80000000);
        preload(32'h2004, 32'h000000FF);
        clear_seen();
        do_req(0, 32'h2003, 2'b01, 1, $urandom);
        check("lh_rsp", last_rsp, 32'hFFFFFF80);
        check("lh_masks", {seen_mask[0], seen_mask[1]}, {4'b1000, 4'b0001});
        idle(1);

        fixed_waits = 3;
        do_req(0, 32'h4000, 2'b10, 0, 32'h0);
        fixed_waits = -1;
        check("bp_stall", last_stall, 5);
        check("bp_rsp", last_rsp, init_w(32'h4000));
        idle(1);

        clear_seen();
        do_req(0, 32'hFFFFFFFE, 2'b10, 0, 32'h0);
        check("wrap_n", seen_addr.size(), 2);
        if (seen_addr.size() == 2)
            check("wrap_beats", {seen_addr[0], seen_mask[0], seen_addr[1], seen_mask[1]},
                  {32'hFFFFFFFC, 4'b1100, 32'h00000000, 4'b0011});

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            if ($urandom % 2 == 0) idle(int'($urandom_range(1, 3)));
            a = ($urandom % 4 == 0) ? 32'hFFFFFFE0 + $urandom_range(0, 31) : 32'h100 + $urandom_range(0, 63);
            do_req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom);
        end
        idle(2);

        fixed_waits = 10;
        dc = done_cnt;
        model(1, 32'h9006, 2'b10, 0, 32'h11223344);
        req_write = 1; req_addr = 32'h9006; req_size = 2'b10; req_signed = 0; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_valid && bus_addr == 32'h9008) && n < 100);
        check("reach_second", {bus_valid, bus_addr}, {1'b1, 32'h9008});
        #2 rst_ni = 1'b0;
        #1 check("reset_mid_second", {bus_valid, stall, done}, 0);
        req_valid = 1'b0;
        beat_q.delete(); rsp_q.delete();
        in_beat = 0; fixed_waits = -1;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", done_cnt, dc);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        idle(1);
        clear_seen();
        do_req(1, 32'h10, 2'b00, 0, 32'h0000005A);
        check("sb_after_reset", {32'(seen_addr.size()), seen_addr[0], seen_mask[0]}, {32'd1, 32'h10, 4'b0001});
        check("sb_done_count", done_cnt, dc + 1);
        idle(3);
        check("queues_drained", {32'(beat_q.size()), 32'(rsp_q.size())}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
